alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 31 +++
 rtl/alu_arbiter_alu.sv | 35 +++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for clients of the 32-bit ALU.
// Holds the ALU op-code constants, the arbiter FSM state encodings and the
// latched-operation record type. Contains no ports.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  // ALU op codes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;  // in2 << in1
  localparam logic [2:0] OP_SRL  = 3'b101;  // in1 >> in2, logical
  localparam logic [2:0] OP_SLTU = 3'b110;  // unsigned in1 < in2
  localparam logic [2:0] OP_PASS = 3'b111;  // in2

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // One accepted operation, captured at the request handshake
  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [2:0]        control;
    logic              owner;    // 0 = requester 0, 1 = requester 1
  } op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by the arbiter.
// Ports:
//   in1_i, in2_i  : operands
//   control_i     : op code (OP_* in alu_arbiter_pkg)
//   result_o      : result, modulo 2^32
//   zero_o        : 1 iff in1_i == in2_i, whatever the op code
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] in1_i,
  input  logic [DATA_W-1:0] in2_i,
  input  logic [2:0]        control_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (control_i)
      OP_ADD:  result_o = in1_i + in2_i;
      OP_SUB:  result_o = in1_i - in2_i;
      OP_AND:  result_o = in1_i & in2_i;
      OP_OR:   result_o = in1_i | in2_i;
      // Shift amount is the full 32-bit operand; amounts >= 32 give 0.
      OP_SLL:  result_o = in2_i << in1_i;
      OP_SRL:  result_o = in1_i >> in2_i;
      OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, (in1_i < in2_i)};
      OP_PASS: result_o = in2_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (in1_i == in2_i);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU.
// A request is granted in IDLE, executed for exactly one cycle (EXEC) and
// its result held in RESP until the owning requester takes it.
//
// Handshake rule (both request and response channels): a transfer happens
// on a rising clk edge where valid and ready are both high; valid never
// depends on ready, and nothing is transferred on any other edge.
//
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   req_valid0/1, req_ready0/1  : request channels
//   req_in1_0/1, req_in2_0/1    : operands per requester
//   req_control0/1              : ALU op code per requester
//   rsp_valid0/1, rsp_ready0/1  : response channels
//   rsp_out, rsp_zero           : registered result and zero flag (shared)
//   busy                        : FSM not in IDLE
//   op_count                    : completed response handshakes (wrapping)
//   dbg_state_o                 : current FSM state (ST_* encodings)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [DATA_W-1:0] req_in1_0,
  input  logic [DATA_W-1:0] req_in2_0,
  input  logic [DATA_W-1:0] req_in1_1,
  input  logic [DATA_W-1:0] req_in2_1,
  input  logic [2:0]        req_control0,
  input  logic [2:0]        req_control1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  input  logic              rsp_ready0,
  input  logic              rsp_ready1,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic [1:0]        dbg_state_o
);

  logic [1:0]        state_q,      state_d;
  op_t               op_q,         op_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rsp_out_q,    rsp_out_d;
  logic              rsp_zero_q,   rsp_zero_d;
  logic [CNT_W-1:0]  op_count_q,   op_count_d;

  logic              idle;
  logic              grant0;
  logic              grant1;
  logic              rsp_hs;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // The ALU always sees the latched operands, so its output is settled
  // during EXEC regardless of what the requesters drive.
  alu_arbiter_alu u_alu (
    .in1_i     (op_q.in1),
    .in2_i     (op_q.in2),
    .control_i (op_q.control),
    .result_o  (alu_result),
    .zero_o    (alu_zero)
  );

  assign idle = (state_q == ST_IDLE);

  // Under contention the requester that did not win last time is granted;
  // last_grant_q resets to 1 so requester 0 wins the first contention.
  assign grant0 = req_valid0 & (~req_valid1 | last_grant_q);
  assign grant1 = req_valid1 & (~req_valid0 | ~last_grant_q);

  // Ready is held low while reset is asserted so no transfer is offered.
  assign req_ready0 = idle & grant0 & ~reset;
  assign req_ready1 = idle & grant1 & ~reset;

  // Only the owner sees a response; the other rsp_ready is ignored.
  assign rsp_valid0 = (state_q == ST_RESP) & ~op_q.owner;
  assign rsp_valid1 = (state_q == ST_RESP) &  op_q.owner;
  assign rsp_hs     = (rsp_valid0 & rsp_ready0) | (rsp_valid1 & rsp_ready1);

  assign rsp_out     = rsp_out_q;
  assign rsp_zero    = rsp_zero_q;
  assign busy        = ~idle;
  assign op_count    = op_count_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_grant_d = last_grant_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ready0) begin
          op_d         = '{in1: req_in1_0, in2: req_in2_0,
                           control: req_control0, owner: 1'b0};
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (req_ready1) begin
          op_d         = '{in1: req_in1_1, in2: req_in2_1,
                           control: req_control1, owner: 1'b1};
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_out_d  = alu_result;
        rsp_zero_d = alu_zero;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      last_grant_q <= 1'b1;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_grant_q <= last_grant_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      op_count_q   <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_alu_arbiter;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_ready0, req_ready1;
  logic [31:0] req_in1_0 = '0, req_in2_0 = '0, req_in1_1 = '0, req_in2_1 = '0;
  logic [2:0]  req_control0 = '0, req_control1 = '0;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0 = 1'b0, rsp_ready1 = 1'b0;
  logic [31:0] rsp_out;
  logic        rsp_zero;
  logic        busy;
  logic [CNT_W-1:0] op_count;
  logic [1:0]  dbg_state;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid0   (req_valid0),
    .req_valid1   (req_valid1),
    .req_ready0   (req_ready0),
    .req_ready1   (req_ready1),
    .req_in1_0    (req_in1_0),
    .req_in2_0    (req_in2_0),
    .req_in1_1    (req_in1_1),
    .req_in2_1    (req_in2_1),
    .req_control0 (req_control0),
    .req_control1 (req_control1),
    .rsp_valid0   (rsp_valid0),
    .rsp_valid1   (rsp_valid1),
    .rsp_ready0   (rsp_ready0),
    .rsp_ready1   (rsp_ready1),
    .rsp_out      (rsp_out),
    .rsp_zero     (rsp_zero),
    .busy         (busy),
    .op_count     (op_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the op-code table.
  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = (a < 32) ? (b << a[4:0]) : 32'd0;
      3'd5: r = (b < 32) ? (a >> b[4:0]) : 32'd0;
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: r = b;
    endcase
    return r;
  endfunction

  // Transaction model: one operation in flight; age counts cycles since
  // acceptance (1 = computing, >=2 = result offered to its owner).
  logic [31:0] exp_q[$];   // results of accepted ops not yet published
  bit          zq[$];
  bit          m_busy  = 0;
  int          m_age   = 0;
  bit          m_owner = 0;
  bit          m_last  = 1;
  logic [31:0] m_out   = '0;
  bit          m_zero  = 0;
  int          m_cnt   = 0;
  bit          m_g0, m_g1;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
      m_out = '0; m_zero = 0; m_cnt = 0;
      exp_q.delete(); zq.delete();
    end else begin
      m_g0 = req_valid0 && (!req_valid1 || m_last);
      m_g1 = req_valid1 && (!req_valid0 || !m_last);
      chk1("m_req_ready0", req_ready0, !m_busy && m_g0);
      chk1("m_req_ready1", req_ready1, !m_busy && m_g1);
      chk1("m_rsp_valid0", rsp_valid0, m_busy && m_age >= 2 && !m_owner);
      chk1("m_rsp_valid1", rsp_valid1, m_busy && m_age >= 2 && m_owner);
      chk1("m_busy", busy, m_busy);
      chk32("m_rsp_out", rsp_out, m_out);
      chk1("m_rsp_zero", rsp_zero, m_zero);
      chk32("m_op_count", 32'(op_count), 32'(m_cnt % 16));
      // advance the model across the coming rising edge
      if (!m_busy) begin
        if (m_g0 || m_g1) begin
          m_owner = m_g0 ? 1'b0 : 1'b1;
          m_last  = m_owner;
          m_busy  = 1;
          m_age   = 1;
          if (m_g0) begin
            exp_q.push_back(alu_ref(req_control0, req_in1_0, req_in2_0));
            zq.push_back(req_in1_0 == req_in2_0);
          end else begin
            exp_q.push_back(alu_ref(req_control1, req_in1_1, req_in2_1));
            zq.push_back(req_in1_1 == req_in2_1);
          end
        end
      end else if (m_age == 1) begin
        m_age  = 2;
        m_out  = exp_q.pop_front();
        m_zero = zq.pop_front();
      end else if (m_owner ? rsp_ready1 : rsp_ready0) begin
        m_busy = 0;
        m_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit sel(input int id);
    case (id)
      0: return req_ready0;
      1: return req_ready1;
      2: return rsp_valid0;
      default: return rsp_valid1;
    endcase
  endfunction

  // Waits (bounded) for a negedge at which the selected output is high.
  task automatic wait_hi(input int id, input string name);
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = sel(id);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for output %0d", name, id);
    end
  endtask

  task automatic drive_req(input int k, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b);
    if (k == 0) begin
      req_valid0 = 1; req_control0 = c; req_in1_0 = a; req_in2_0 = b;
    end else begin
      req_valid1 = 1; req_control1 = c; req_in1_1 = a; req_in2_1 = b;
    end
  endtask

  task automatic drop_req(input int k);
    if (k == 0) req_valid0 = 0;
    else        req_valid1 = 0;
  endtask

  // Full operation on requester k; its rsp_ready must already be high.
  task automatic run_op(input int k, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string name);
    drive_req(k, c, a, b);
    wait_hi(k, name);
    @(posedge clk); #1;
    drop_req(k);
    wait_hi(2 + k, name);
    chk32(name, rsp_out, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1;
    req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    chk32("reset_out", rsp_out, 32'd0);
    chk1("reset_zero", rsp_zero, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk32("reset_count", 32'(op_count), 32'd0);
    chk1("reset_rv0", rsp_valid0, 1'b0);
    chk1("reset_rv1", rsp_valid1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset during EXEC discards the operation.
    rsp_ready0 = 1;
    drive_req(0, 3'd0, 32'd3, 32'd3);
    wait_hi(0, "exec_reset_accept");
    @(posedge clk); #1;
    drop_req(0);
    chk1("exec_busy", busy, 1'b1);
    #1 reset = 1;
    #1;
    chk32("rst_out", rsp_out, 32'd0);
    chk1("rst_zero", rsp_zero, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rv0", rsp_valid0, 1'b0);
    chk1("rst_rdy0", req_ready0, 1'b0);
    chk32("rst_count", 32'(op_count), 32'd0);
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("no_rsp_after_rst", rsp_valid0, 1'b0);
    end
    chk32("count_after_rst", 32'(op_count), 32'd0);
    @(posedge clk); #1;

    // Port 0 add with exact latency.
    drive_req(0, 3'd0, 32'd5, 32'd7);
    @(negedge clk);
    chk1("add_ready0", req_ready0, 1'b1);
    @(posedge clk); #1;
    drop_req(0);
    @(negedge clk);
    chk1("add_lat_exec", rsp_valid0, 1'b0);
    @(negedge clk);
    chk1("add_rv0", rsp_valid0, 1'b1);
    chk32("add_out", rsp_out, 32'd12);
    chk1("add_zero", rsp_zero, 1'b0);
    chk32("model_add", m_out, 32'd12);
    @(negedge clk);
    chk32("add_count", 32'(op_count), 32'd1);
    chk1("add_idle", busy, 1'b0);
    @(posedge clk); #1;

    // Contention after reset, held response, third contention.
    do_reset();
    rsp_ready0 = 1; rsp_ready1 = 0;
    drive_req(0, 3'd1, 32'd9, 32'd9);
    drive_req(1, 3'd3, 32'hF0, 32'h0F);
    @(negedge clk);
    chk1("cont_rdy0", req_ready0, 1'b1);
    chk1("cont_rdy1", req_ready1, 1'b0);
    @(posedge clk); #1;
    drop_req(0);
    wait_hi(2, "cont_p0_rsp");
    chk32("cont_p0_out", rsp_out, 32'd0);
    chk1("cont_p0_zero", rsp_zero, 1'b1);
    wait_hi(1, "cont_p1_grant");
    @(posedge clk); #1;
    drop_req(1);
    drive_req(0, 3'd0, 32'd1, 32'd2);
    wait_hi(3, "cont_p1_rsp");
    chk32("model_or", m_out, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      chk1("hold_rv1", rsp_valid1, 1'b1);
      chk32("hold_out", rsp_out, 32'hFF);
      chk1("hold_zero", rsp_zero, 1'b0);
      chk1("hold_rdy0", req_ready0, 1'b0);
      chk1("hold_rdy1", req_ready1, 1'b0);
      chk1("hold_busy", busy, 1'b1);
      @(posedge clk); #1;
      if (i < 3) @(negedge clk);
    end
    rsp_ready1 = 1;
    drive_req(1, 3'd7, 32'd0, 32'd77);
    wait_hi(0, "third_grant");
    chk1("third_rdy1", req_ready1, 1'b0);
    @(posedge clk); #1;
    drop_req(0);
    wait_hi(2, "third_p0_rsp");
    chk32("third_p0_out", rsp_out, 32'd3);
    wait_hi(1, "third_p1_grant");
    @(posedge clk); #1;
    drop_req(1);
    wait_hi(3, "third_p1_rsp");
    chk32("third_p1_out", rsp_out, 32'd77);
    @(posedge clk); #1;

    // Op-code corner cases.
    run_op(0, 3'd4, 32'd4, 32'd1, 32'd16, "sll_4");
    run_op(0, 3'd6, 32'hFFFFFFFF, 32'd1, 32'd0, "sltu_max");
    run_op(1, 3'd7, 32'd123, 32'hABCD, 32'hABCD, "pass_in2");
    run_op(0, 3'd5, 32'h80000000, 32'd31, 32'd1, "srl_31");

    // Counter wrap with a 4-bit counter.
    do_reset();
    rsp_ready0 = 1;
    for (int i = 0; i < 15; i++) run_op(0, 3'd0, 32'(i), 32'd1, 32'(i + 1), "wrap_fill");
    @(negedge clk);
    chk32("count_full", 32'(op_count), 32'd15);
    @(posedge clk); #1;
    run_op(0, 3'd2, 32'hF0F0, 32'h0FF0, 32'h00F0, "and_wrap");
    @(negedge clk);
    chk32("count_wrap", 32'(op_count), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      req_valid0   = ($urandom_range(0, 1) == 1);
      req_valid1   = ($urandom_range(0, 1) == 1);
      req_control0 = 3'($urandom_range(0, 7));
      req_control1 = 3'($urandom_range(0, 7));
      req_in1_0    = $urandom();
      req_in2_0    = $urandom();
      req_in1_1    = $urandom();
      req_in2_1    = $urandom();
      if ($urandom_range(0, 3) == 0) req_in2_0 = req_in1_0;
      if ($urandom_range(0, 3) == 0) req_in2_1 = req_in1_1;
      if ($urandom_range(0, 3) == 0) req_in1_0 = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) req_in2_1 = 32'($urandom_range(0, 40));
      rsp_ready0   = ($urandom_range(0, 9) < 7);
      rsp_ready1   = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    req_valid0 = 0; req_valid1 = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
